// File: rtl/mig_tg_pkg.sv
// mig_tg_pkg: shared types and constants for the MIG
// traffic generator / checker.
package mig_tg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    W2R,
    READ,
    DRAIN,
    FINISH
  } state_t;

  localparam logic [1:0] PAT_INC2  = 2'd0;
  localparam logic [1:0] PAT_ADDR  = 2'd1;
  localparam logic [1:0] PAT_WALK1 = 2'd2;
  localparam logic [1:0] PAT_ALT   = 2'd3;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_tg_pattern.sv
// mig_tg_pattern: combinational data pattern for beat idx
// at beat address addr.
import mig_tg_pkg::*;

module mig_tg_pattern #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 29,
  parameter int CNT_W  = 16
) (
  input  logic [CNT_W-1:0]  idx,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] data
);

  localparam int REP = DATA_W / ADDR_W + 1;

  logic [31:0] pos;

  assign pos = 32'(idx) % 32'(DATA_W);

  always_comb begin
    data = '0;
    unique case (sel)
      PAT_INC2:  data = DATA_W'({idx, 1'b0});
      PAT_ADDR:  data = DATA_W'({REP{addr}});
      PAT_WALK1: data = DATA_W'(1) << pos;
      PAT_ALT:   data = {DATA_W{idx[0]}};
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/mig_traffic_checker.sv
// mig_traffic_checker: write-then-read traffic generator and
// data checker for the MIG 7-series app interface.
import mig_tg_pkg::*;

module mig_traffic_checker #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 29,
  parameter int ADDR_STEP = 8,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                ui_clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic [1:0]          pattern_sel,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_beats,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic                app_rd_data_valid,
  input  logic [DATA_W-1:0]   app_rd_data,
  output logic                busy,
  output logic                done,
  output logic                tg_compare_error,
  output logic [CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  n_beats, n_nx;
  logic [1:0]        sel, sel_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [CNT_W-1:0]  wcmd, wcmd_nx;
  logic [CNT_W-1:0]  wdat, wdat_nx;
  logic [ADDR_W-1:0] wdat_addr, wdat_addr_nx;
  logic [CNT_W-1:0]  rcmd, rcmd_nx;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_nx;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
  logic [TW-1:0]     idle, idle_nx;

  logic [ADDR_W-1:0] addr_nx;
  logic [2:0]        cmd_nx;
  logic              en_nx;
  logic              wren_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              busy_nx;
  logic              done_nx;
  logic              err_nx;
  logic [CNT_W-1:0]  ecnt_nx;
  logic [ADDR_W-1:0] ferr_nx;
  logic              tmo_nx;

  logic [DATA_W-1:0] gen_data;
  logic [DATA_W-1:0] chk_data;
  logic              beat;
  logic              miss;

  mig_tg_pattern #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_gen (
    .idx (wdat_nx),
    .addr(wdat_addr_nx),
    .sel (sel_nx),
    .data(gen_data)
  );

  mig_tg_pattern #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .idx (rd_cnt),
    .addr(rd_addr),
    .sel (sel),
    .data(chk_data)
  );

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  assign beat = app_rd_data_valid
              && (state == READ || state == DRAIN)
              && (rd_cnt < n_beats);
  assign miss = app_rd_data != chk_data;

  // New data is only loaded when a beat is offered, so a
  // stalled beat keeps its value.
  assign wdata_nx = wren_nx ? gen_data : app_wdf_data;

  always_comb begin
    state_nx     = state;
    n_nx         = n_beats;
    sel_nx       = sel;
    base_nx      = base;
    wcmd_nx      = wcmd;
    wdat_nx      = wdat;
    wdat_addr_nx = wdat_addr;
    rcmd_nx      = rcmd;
    rd_cnt_nx    = rd_cnt;
    rd_addr_nx   = rd_addr;
    idle_nx      = idle;
    addr_nx      = app_addr;
    cmd_nx       = app_cmd;
    en_nx        = app_en;
    wren_nx      = app_wdf_wren;
    err_nx       = tg_compare_error;
    ecnt_nx      = err_count;
    ferr_nx      = first_err_addr;
    tmo_nx       = timeout_err;

    if (beat) begin
      rd_cnt_nx  = rd_cnt + 1'b1;
      rd_addr_nx = rd_addr + STEP;
      if (miss) begin
        err_nx = 1'b1;
        if (err_count != '1)
          ecnt_nx = err_count + 1'b1;
        if (!tg_compare_error)
          ferr_nx = rd_addr;
      end
    end

    unique case (state)
      IDLE: begin
        if (start && init_calib_complete) begin
          n_nx         = num_beats;
          sel_nx       = pattern_sel;
          base_nx      = base_addr;
          wcmd_nx      = '0;
          wdat_nx      = '0;
          wdat_addr_nx = base_addr;
          rcmd_nx      = '0;
          rd_cnt_nx    = '0;
          rd_addr_nx   = base_addr;
          idle_nx      = '0;
          err_nx       = 1'b0;
          ecnt_nx      = '0;
          ferr_nx      = '0;
          tmo_nx       = 1'b0;
          addr_nx      = base_addr;
          cmd_nx       = CMD_WRITE;
          if (num_beats == '0) begin
            state_nx = FINISH;
          end else begin
            state_nx = WRITE;
            en_nx    = 1'b1;
            wren_nx  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (app_en && app_rdy) begin
          wcmd_nx = wcmd + 1'b1;
          addr_nx = app_addr + STEP;
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          wdat_nx      = wdat + 1'b1;
          wdat_addr_nx = wdat_addr + STEP;
        end
        en_nx   = wcmd_nx < n_beats;
        // data may run ahead of its command
        wren_nx = (wdat_nx < n_beats)
               && ({1'b0, wdat_nx}
                   <= {1'b0, wcmd_nx} + 1'b1);
        if (wcmd_nx == n_beats
            && wdat_nx == n_beats) begin
          state_nx = W2R;
          addr_nx  = base;
        end
      end
      W2R: begin
        state_nx = READ;
        rcmd_nx  = '0;
        en_nx    = 1'b1;
        cmd_nx   = CMD_READ;
      end
      READ: begin
        if (app_en && app_rdy) begin
          rcmd_nx = rcmd + 1'b1;
          addr_nx = app_addr + STEP;
        end
        en_nx = rcmd_nx < n_beats;
        if (!en_nx) begin
          state_nx = DRAIN;
          idle_nx  = '0;
        end
      end
      DRAIN: begin
        idle_nx = beat ? '0 : idle + 1'b1;
        if (rd_cnt_nx == n_beats) begin
          state_nx = FINISH;
        end else if (idle_nx == TW'(TIMEOUT)) begin
          tmo_nx   = 1'b1;
          state_nx = FINISH;
        end
      end
      FINISH: state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        wren_nx  = 1'b0;
      end
    endcase

    busy_nx = state_nx != IDLE;
    done_nx = state == FINISH;
  end

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state            <= IDLE;
      n_beats          <= '0;
      sel              <= '0;
      base             <= '0;
      wcmd             <= '0;
      wdat             <= '0;
      wdat_addr        <= '0;
      rcmd             <= '0;
      rd_cnt           <= '0;
      rd_addr          <= '0;
      idle             <= '0;
      app_addr         <= '0;
      app_cmd          <= '0;
      app_en           <= 1'b0;
      app_wdf_data     <= '0;
      app_wdf_wren     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      tg_compare_error <= 1'b0;
      err_count        <= '0;
      first_err_addr   <= '0;
      timeout_err      <= 1'b0;
    end else begin
      state            <= state_nx;
      n_beats          <= n_nx;
      sel              <= sel_nx;
      base             <= base_nx;
      wcmd             <= wcmd_nx;
      wdat             <= wdat_nx;
      wdat_addr        <= wdat_addr_nx;
      rcmd             <= rcmd_nx;
      rd_cnt           <= rd_cnt_nx;
      rd_addr          <= rd_addr_nx;
      idle             <= idle_nx;
      app_addr         <= addr_nx;
      app_cmd          <= cmd_nx;
      app_en           <= en_nx;
      app_wdf_data     <= wdata_nx;
      app_wdf_wren     <= wren_nx;
      busy             <= busy_nx;
      done             <= done_nx;
      tg_compare_error <= err_nx;
      err_count        <= ecnt_nx;
      first_err_addr   <= ferr_nx;
      timeout_err      <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_mig_traffic_checker.sv
// tb_mig_traffic_checker: directed runs against a small MIG
// memory model with a write/read scoreboard.
module tb_mig_traffic_checker;
  import mig_tg_pkg::*;

  localparam int DW   = 256;
  localparam int AW   = 29;
  localparam int CW   = 16;
  localparam int STEP = 8;

  logic          ui_clk = 1'b0;
  logic          sys_rst;
  logic          init_calib_complete;
  logic          start;
  logic [1:0]    pattern_sel;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_beats;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic          app_rd_data_valid;
  logic [DW-1:0] app_rd_data;
  logic          busy;
  logic          done;
  logic          tg_compare_error;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic          timeout_err;

  mig_traffic_checker #(
    .DATA_W(DW), .ADDR_W(AW), .ADDR_STEP(STEP),
    .CNT_W(CW), .TIMEOUT(1024)
  ) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst),
    .init_calib_complete(init_calib_complete),
    .start(start), .pattern_sel(pattern_sel),
    .base_addr(base_addr), .num_beats(num_beats),
    .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .busy(busy),
    .done(done), .tg_compare_error(tg_compare_error),
    .err_count(err_count),
    .first_err_addr(first_err_addr),
    .timeout_err(timeout_err)
  );

  always #5 ui_clk = ~ui_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wexp_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  wexp_t         exp_w[$];
  logic [AW-1:0] exp_r[$];
  logic [AW-1:0] wq[$];
  logic [DW-1:0] dq[$];
  rd_t           rdq[$];
  logic [DW-1:0] mem[logic [AW-1:0]];

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  en_seen = 0;
  int  rbeat = 0;
  int  n_run = 0;
  bit  stall = 0;
  bit  corrupt = 0;
  bit  withhold = 0;
  bit  en_pend = 0;
  bit  wr_pend = 0;
  time last_valid_t = 0;
  logic [AW-1:0] p_addr;
  logic [2:0]    p_cmd;
  logic [DW-1:0] p_data;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(
    input int i, input logic [AW-1:0] a,
    input logic [1:0] s);
    logic [DW-1:0] v;
    v = '0;
    case (s)
      2'd0: v = DW'(2 * i);
      2'd1: for (int b = 0; b < DW; b++) v[b] = a[b % AW];
      2'd2: v[i % DW] = 1'b1;
      default: if (i % 2 == 1) v = '1;
    endcase
    return v;
  endfunction

  // MIG model: samples on the falling edge what the next
  // rising edge will accept.
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    wexp_t e;
    rd_t r;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(negedge ui_clk);
      cyc++;
      if (en_pend)
        chk("en_hold", {app_en, app_cmd, app_addr},
            {1'b1, p_cmd, p_addr});
      if (wr_pend)
        chk("wdf_hold", {app_wdf_wren, app_wdf_data},
            {1'b1, p_data});
      if (app_en) en_seen++;
      app_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (app_en && app_rdy) begin
        if (app_cmd == CMD_WRITE) begin
          wq.push_back(app_addr);
        end else begin
          r.data = mem.exists(app_addr) ? mem[app_addr] : '0;
          r.due = cyc + 4;
          rdq.push_back(r);
          chk("rd_expected", DW'(exp_r.size() != 0), 1);
          if (exp_r.size() != 0)
            chk("rd_addr", app_addr, exp_r.pop_front());
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        dq.push_back(app_wdf_data);
        chk("wdf_end", app_wdf_end, 1);
      end
      while (wq.size() > 0 && dq.size() > 0) begin
        a = wq.pop_front();
        d = dq.pop_front();
        mem[a] = d;
        chk("wr_expected", DW'(exp_w.size() != 0), 1);
        if (exp_w.size() != 0) begin
          e = exp_w.pop_front();
          chk("wr_addr", a, e.addr);
          chk("wr_data", d, e.data);
        end
      end
      en_pend = app_en && !app_rdy;
      p_addr = app_addr;
      p_cmd = app_cmd;
      wr_pend = app_wdf_wren && !app_wdf_rdy;
      p_data = app_wdf_data;
      app_rd_data_valid = 1'b0;
      if (rdq.size() > 0 && rdq[0].due <= cyc) begin
        r = rdq.pop_front();
        if (!(withhold && rbeat == n_run - 1)) begin
          app_rd_data_valid = 1'b1;
          app_rd_data = (corrupt && (rbeat == 5 || rbeat == 9))
                      ? ~r.data : r.data;
          last_valid_t = $time;
        end
        rbeat++;
      end
    end
  end

  task automatic launch(input int n, input logic [AW-1:0] b,
                        input logic [1:0] s, input bit push);
    logic [AW-1:0] a;
    wexp_t e;
    if (push) begin
      for (int i = 0; i < n; i++) begin
        a = b + AW'(i * STEP);
        e.addr = a;
        e.data = pat(i, a, s);
        exp_w.push_back(e);
        exp_r.push_back(a);
      end
      rbeat = 0;
      n_run = n;
    end
    @(negedge ui_clk);
    num_beats = CW'(n);
    base_addr = b;
    pattern_sel = s;
    start = 1'b1;
    @(negedge ui_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge ui_clk);
      if (done) got = 1;
    end
    chk("done_seen", DW'(got), 1);
    @(negedge ui_clk);
    chk("done_pulse", {done, busy}, 0);
  endtask

  task automatic post(input string tag, input bit err,
                      input int cnt, input logic [AW-1:0] fa,
                      input bit tmo);
    chk({tag, "_err"}, tg_compare_error, err);
    chk({tag, "_cnt"}, err_count, cnt);
    chk({tag, "_faddr"}, first_err_addr, fa);
    chk({tag, "_tmo"}, timeout_err, tmo);
    chk({tag, "_left"},
        exp_w.size() + exp_r.size() + wq.size() + dq.size(), 0);
  endtask

  initial begin
    int  gap;
    bit  hit;
    sys_rst = 1'b0;
    init_calib_complete = 1'b0;
    start = 1'b0;
    num_beats = '0;
    base_addr = '0;
    pattern_sel = '0;
    repeat (3) @(negedge ui_clk);
    chk("rst_ctl", {app_en, app_wdf_wren, app_wdf_end, busy,
        done, tg_compare_error, timeout_err, app_cmd}, 0);
    chk("rst_val", {app_addr, err_count, first_err_addr}, 0);
    chk("rst_data", app_wdf_data, 0);
    chk("rst_mask", app_wdf_mask, 0);
    sys_rst = 1'b1;
    init_calib_complete = 1'b1;
    @(negedge ui_clk);

    // ideal memory, increment-by-2 data
    launch(20, 29'h0, 2'd0, 1);
    chk("t1_busy", busy, 1);
    wait_done(1000);
    post("t1", 0, 0, 0, 0);

    // random stalls, walking one, stray start while busy
    stall = 1;
    launch(64, 29'h1000, 2'd2, 1);
    repeat (10) @(negedge ui_clk);
    chk("t2_busy", busy, 1);
    start = 1'b1;
    num_beats = CW'(3);
    base_addr = 29'h999;
    @(negedge ui_clk);
    start = 1'b0;
    wait_done(3000);
    post("t2", 0, 0, 0, 0);
    stall = 0;

    // corrupted read beats 5 and 9
    corrupt = 1;
    launch(16, 29'h100, 2'd1, 1);
    wait_done(1000);
    post("t3", 1, 2, 29'h128, 0);
    corrupt = 0;

    // last read beat withheld
    withhold = 1;
    launch(8, 29'h300, 2'd3, 1);
    wait_done(2000);
    gap = int'(($time - last_valid_t) / 10) - 1;
    chk("t4_gap", DW'(gap >= 1020 && gap <= 1032), 1);
    post("t4", 0, 0, 0, 1);
    withhold = 0;
    rdq.delete();

    // zero-length run
    en_seen = 0;
    launch(0, 29'h50, 2'd0, 1);
    chk("t5_busy", {busy, done}, 2'b10);
    @(negedge ui_clk);
    chk("t5_done", {busy, done}, 2'b01);
    @(negedge ui_clk);
    chk("t5_after", {busy, done}, 2'b00);
    chk("t5_en", en_seen, 0);
    post("t5", 0, 0, 0, 0);

    // start before calibration
    init_calib_complete = 1'b0;
    en_seen = 0;
    hit = 0;
    launch(4, 29'h60, 2'd0, 0);
    repeat (6) begin
      @(negedge ui_clk);
      if (done || busy) hit = 1;
    end
    chk("t6_idle", {hit, 1'b0, en_seen[7:0]}, 0);
    init_calib_complete = 1'b1;

    // reset in the middle of the read phase
    launch(32, 29'h200, 2'd3, 1);
    hit = 0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge ui_clk);
      if (app_en && app_cmd == CMD_READ) hit = 1;
    end
    chk("t7_read", DW'(hit), 1);
    repeat (3) @(negedge ui_clk);
    @(posedge ui_clk);
    #3;
    sys_rst = 1'b0;
    #1;
    exp_w.delete();
    exp_r.delete();
    wq.delete();
    dq.delete();
    rdq.delete();
    en_pend = 0;
    wr_pend = 0;
    app_rd_data_valid = 1'b0;
    chk("t7_ctl", {app_en, app_wdf_wren, busy, done,
        tg_compare_error, timeout_err, app_cmd}, 0);
    chk("t7_val", {app_addr, err_count, first_err_addr}, 0);
    chk("t7_data", app_wdf_data, 0);
    repeat (3) begin
      @(negedge ui_clk);
      chk("t7_hold", {busy, done, app_en}, 0);
    end
    sys_rst = 1'b1;
    @(negedge ui_clk);
    launch(16, 29'h40, 2'd1, 1);
    wait_done(1000);
    post("t8", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
